hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised register scoreboard and forwarding controller for the pipelined datapath.
//  Tracks in-flight destination registers through DEPTH post-decode stages (stage 0 = E,
//  stage DEPTH-1 = W) and produces:
//   - a decode stall for producer-consumer hazards;
//   - one-hot-encoded forward selects for the instruction in E.
//  Generalises the fixed E/M/W match logic to any depth, register count and per-instruction
//  result latency.
// PARAMETERS
//  DEPTH   3   post-decode stages tracked (>=2); stage 0 = E, DEPTH-1 = W
//  NREGS   16  architectural registers; RA_W = $clog2(NREGS) (localparam)
//  LAT_W   2   width of latency field; result latency L is in 0..DEPTH-2
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  issue_valid  in   1           decode holds a real instruction this cycle
//  issue_ra1    in   RA_W        decode source 1 register
//  issue_ra2    in   RA_W        decode source 2 register
//  issue_use1   in   1           source 1 is actually read
//  issue_use2   in   1           source 2 is actually read
//  issue_wa     in   RA_W        decode destination register
//  issue_we     in   1           decode instruction writes issue_wa
//  issue_lat    in   LAT_W       stage index at whose end the result exists (ALU=0, load=1)
//  flush_e      in   1           branch taken: the entry entering stage 0 becomes a bubble
//  stall_d      out  1           hold F/D; a bubble is inserted into E
//  fwd1_sel     out  DEPTH       one-hot forward source for E operand 1; bit j = stage j;
//                                bit 0 is never set; all-zero = use register file value
//  fwd2_sel     out  DEPTH       same for operand 2
// BEHAVIOUR
//  - Entry per stage: {v, we, wa, lat, ra1, use1, ra2, use2}. Every cycle the entries
//    shift from stage k to k+1, and stage DEPTH-1 retires.
//  - Stage 0 loads the decode fields when issue_valid & ~stall_d & ~flush_e; otherwise it
//    loads a bubble (v=0).
//  - flush_e overrides stall_d for stage 0. stall_d is still output so that F/D hold.
//  - Producer p at stage k: a live producer with a match has v & we & (wa == src) & use.
//  - Hazard: stall_d = issue_valid & any live producer matching issue_ra1 or issue_ra2 with
//    k < lat. This is combinational from the decode inputs and registered entries.
//  - Forward: for the E entry (stage 0, v=1) and each operand, the set of candidates is all
//    stages j in 1..DEPTH-1 with a live producer match and j > lat_j.
//    - fwdN_sel = one-hot of the smallest such j (youngest producer wins).
//    - If the youngest matching producer has j <= lat_j, the stall has already prevented
//      this case; still drive zero.
//  - A stage-0 bubble, or use=0, gives fwdN_sel = 0.
//  - Register index NREGS-1 (PC) never matches; it is always read from the register file.
//  - Reset: all v=0; stall_d=0; fwd1_sel=fwd2_sel=0 in the cycle after reset; stall counter
//    cleared. Reset asserted mid-stall drops all entries, and stall_d deasserts on the next
//    cycle.
//  - Latency: stall_d and fwd*_sel are combinational (0 cycles) from inputs and state.
//    Entries advance one stage per clock, with no enable: the pipeline never stalls behind E.
//  - Entries with lat >= DEPTH-1 are illegal. The behaviour is unspecified; a simulation
//    assertion flags them.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds output stall_cnt (32 bits).
//   - stall_cnt increments on every rising edge with stall_d=1, saturates at 32'hFFFFFFFF,
//     and is cleared by reset.
//  HAZARD_STATS_EN undefined: the port and counter are absent; functionality is otherwise
//   identical.
// TESTING
//  1. reset=1 for 2 cycles -> stall_d=0, fwd1_sel=fwd2_sel=0, all entries invalid.
//  2. ALU back-to-back, DEPTH=3: issue wa=R3 we lat=0, then a consumer with ra1=R3
//     -> stall_d=0; next cycle fwd1_sel=3'b010 (M).
//  3. Load-use: issue wa=R2 lat=1, then a consumer with ra2=R2 -> stall_d=1 for exactly 1
//     cycle, E gets a bubble; when the consumer reaches E, fwd2_sel=3'b100 (W).
//  4. Youngest wins: R5 written by stage-2 and stage-1 producers (both lat=0); consumer in E
//     with ra1=R5 -> fwd1_sel=3'b010.
//  5. flush_e with stall_d=1 -> stage 0 bubble; the stalled consumer re-evaluates next cycle;
//     ra1=R15 (PC) with a producer wa=R15 -> fwd1_sel=0, stall_d=0.
//  6. HAZARD_STATS_EN: run 4 load-use pairs -> stall_cnt=4; reset -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and forwarding controller tracking DEPTH post-decode stages.
// Optional HAZARD_STATS_EN adds a saturating 32-bit stall counter output stall_cnt.
module hazard_scoreboard #(
  parameter  int DEPTH = 3,
  parameter  int NREGS = 16,
  parameter  int LAT_W = 2,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  issue_ra1,
  input  logic [RA_W-1:0]  issue_ra2,
  input  logic             issue_use1,
  input  logic             issue_use2,
  input  logic [RA_W-1:0]  issue_wa,
  input  logic             issue_we,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush_e,
  output logic             stall_d,
  output logic [DEPTH-1:0] fwd1_sel,
  output logic [DEPTH-1:0] fwd2_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Per-stage producer fields; source fields are only consulted in E, so only stage 0 keeps them.
  logic             v_p   [DEPTH];
  logic             we_p  [DEPTH];
  logic [RA_W-1:0]  wa_p  [DEPTH];
  logic [LAT_W-1:0] lat_p [DEPTH];
  logic [RA_W-1:0]  ra1_p0, ra2_p0;
  logic             use1_p0, use2_p0;
  logic             load_p0;

  // The PC index is always read from the register file, so it never matches.
  function automatic logic hit(input logic v, input logic we, input logic [RA_W-1:0] wa,
                               input logic [RA_W-1:0] src, input logic use_src);
    return v & we & use_src & (wa == src) & (src != RA_W'(NREGS-1));
  endfunction

  // Youngest matching producer decides; if it is not ready yet, no older one may be used.
  function automatic logic [DEPTH-1:0] pick(input logic [RA_W-1:0] src, input logic use_src);
    logic [DEPTH-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int j = 1; j < DEPTH; j++) begin
      if (!found && hit(v_p[j], we_p[j], wa_p[j], src, use_src)) begin
        found = 1'b1;
        if (j > int'(lat_p[j])) sel[j] = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    stall_d = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < int'(lat_p[k])) &&
          (hit(v_p[k], we_p[k], wa_p[k], issue_ra1, issue_use1) ||
           hit(v_p[k], we_p[k], wa_p[k], issue_ra2, issue_use2)))
        stall_d = 1'b1;
    end
    stall_d = stall_d & issue_valid;
  end

  assign fwd1_sel = v_p[0] ? pick(ra1_p0, use1_p0) : '0;
  assign fwd2_sel = v_p[0] ? pick(ra2_p0, use2_p0) : '0;

  // Flush wins over stall: E takes a bubble either way, F/D hold on stall_d.
  assign load_p0 = issue_valid & ~stall_d & ~flush_e;

  // Stage 0 (E) load and stage k -> k+1 shift of the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) v_p[k] <= 1'b0;
    end else begin
      v_p[0] <= load_p0;
      for (int k = 1; k < DEPTH; k++) v_p[k] <= v_p[k-1];
    end
  end

  // Stage 0 (E) load and stage k -> k+1 shift of the payload fields.
  always_ff @(posedge clk) begin
    we_p[0]  <= issue_we;
    wa_p[0]  <= issue_wa;
    lat_p[0] <= issue_lat;
    ra1_p0   <= issue_ra1;
    ra2_p0   <= issue_ra2;
    use1_p0  <= issue_use1;
    use2_p0  <= issue_use2;
    for (int k = 1; k < DEPTH; k++) begin
      we_p[k]  <= we_p[k-1];
      wa_p[k]  <= wa_p[k-1];
      lat_p[k] <= lat_p[k-1];
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && load_p0 && issue_we) assert (int'(issue_lat) <= DEPTH - 2);
  end
`endif

endmodule
